// File: rtl/conv_pkg.sv
// Shared constants, state encoding and small helpers for the convolution
// frame scheduler and its window address generator.
package conv_pkg;

  // Geometry and word widths
  localparam int IFM_DIM = 7;
  localparam int K       = 3;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;

  // Derived frame dimensions
  localparam int OUT_DIM = IFM_DIM - K + 1;
  localparam int N_IFM   = IFM_DIM * IFM_DIM;
  localparam int N_WGT   = K * K;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;

  // Counter widths
  localparam int WGT_CW  = 4;
  localparam int RES_CW  = 5;
  localparam int RC_W    = 3;

  // Typed terminal values so comparisons stay width-matched
  localparam logic [ADDR_W-1:0] IFM_LAST = ADDR_W'(N_IFM - 1);
  localparam logic [WGT_CW-1:0] WGT_FULL = WGT_CW'(N_WGT);
  localparam logic [RES_CW-1:0] RES_FULL = RES_CW'(N_OUT);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(OUT_DIM - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_W  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Distance from one window base to the next: one word along a row, or
  // skip the K-1 columns that cannot start a window when a row wraps.
  function automatic logic [ADDR_W-1:0] base_step(input logic row_wrap);
    logic [ADDR_W-1:0] step;
    if (row_wrap) begin
      step = ADDR_W'(K);
    end else begin
      step = ADDR_W'(1);
    end
    return step;
  endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window base address generator: walks the OUT_DIM x OUT_DIM grid of
// window origins in raster order, one step per accepted window.
module conv_win_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_last
);

  logic [RC_W-1:0]   r_row;
  logic [RC_W-1:0]   r_col;
  logic [ADDR_W-1:0] r_base;
  logic              r_last;

  logic              w_col_wrap;
  logic [RC_W-1:0]   w_row_nxt;
  logic [RC_W-1:0]   w_col_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_last_nxt;

  // Next grid position, base and last flag for one advance
  always_comb begin
    w_col_wrap = (r_col == RC_LAST);
    if (w_col_wrap) begin
      w_row_nxt = r_row + 3'd1;
      w_col_nxt = 3'd0;
    end else begin
      w_row_nxt = r_row;
      w_col_nxt = r_col + 3'd1;
    end
    w_base_nxt = r_base + base_step(w_col_wrap);
    w_last_nxt = (w_row_nxt == RC_LAST) && (w_col_nxt == RC_LAST);
  end

  // Position registers: clear has priority over advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_base <= '0;
      r_last <= 1'b0;
    end else if (i_clr) begin
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_base <= '0;
      r_last <= 1'b0;
    end else if (i_en) begin
      r_row  <= w_row_nxt;
      r_col  <= w_col_nxt;
      r_base <= w_base_nxt;
      r_last <= w_last_nxt;
    end else begin
      r_row  <= r_row;
      r_col  <= r_col;
      r_base <= r_base;
      r_last <= r_last;
    end
  end

  assign o_base = r_base;
  assign o_last = r_last;

endmodule

// File: rtl/conv_frame_scheduler.sv
// Frame scheduler for the 7x7 IFM / 3x3 weight convolution: turns the
// serial IFM and weight streams into buffer writes, issues the window
// bases to the MAC datapath and closes the frame when all results return.
module conv_frame_scheduler
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_IFM_1,
  input  logic              weight_valid,
  input  logic [DATA_W-1:0] In_Weight_1,
  output logic              ifm_wr_en,
  output logic [ADDR_W-1:0] ifm_wr_addr,
  output logic [DATA_W-1:0] ifm_wr_data,
  output logic              wgt_wr_en,
  output logic [3:0]        wgt_wr_addr,
  output logic [DATA_W-1:0] wgt_wr_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [ADDR_W-1:0] win_base,
  output logic              win_last,
  input  logic              mac_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_overrun
);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_ifm_cnt;
  logic [WGT_CW-1:0] r_wgt_cnt;
  logic [RES_CW-1:0] r_res_cnt;

  logic              r_ifm_wr_en;
  logic [ADDR_W-1:0] r_ifm_wr_addr;
  logic [DATA_W-1:0] r_ifm_wr_data;
  logic              r_wgt_wr_en;
  logic [WGT_CW-1:0] r_wgt_wr_addr;
  logic [DATA_W-1:0] r_wgt_wr_data;
  logic              r_win_valid;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err_short;
  logic              r_err_overrun;

  logic              w_ifm_acc;
  logic [ADDR_W-1:0] w_ifm_idx;
  logic              w_short;
  logic              w_overrun;
  logic              w_done;
  logic              w_frame_start;
  logic              w_wgt_open;
  logic              w_wgt_acc;
  logic [WGT_CW-1:0] w_wgt_cnt_inc;
  logic              w_mac;
  logic [RES_CW-1:0] w_res_inc;
  logic              w_hs;
  logic              w_ag_clr;
  logic [ADDR_W-1:0] w_win_base;
  logic              w_win_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the per-cycle accept/event decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_ifm_acc     = 1'b0;
    w_ifm_idx     = r_ifm_cnt;
    w_short       = 1'b0;
    w_overrun     = 1'b0;
    w_done        = 1'b0;
    w_frame_start = 1'b0;

    w_hs       = r_win_valid && win_ready;
    w_wgt_open = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                 (r_state == ST_WAIT_W);
    // A weight arriving in the cycle a short burst is detected is dropped,
    // since the weight count is being cleared for the aborted frame.
    w_wgt_acc  = weight_valid && w_wgt_open && (r_wgt_cnt < WGT_FULL) &&
                 !((r_state == ST_LOAD) && !in_valid);
    w_wgt_cnt_inc = r_wgt_cnt + {3'd0, w_wgt_acc};
    w_mac      = mac_done && ((r_state == ST_COMPUTE) || (r_state == ST_DRAIN));
    w_res_inc  = r_res_cnt + {4'd0, w_mac};

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_ifm_acc     = 1'b1;
          w_ifm_idx     = '0;
          w_frame_start = 1'b1;
          w_state_nxt   = ST_LOAD;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          w_ifm_acc = 1'b1;
          if (r_ifm_cnt == IFM_LAST) begin
            if (w_wgt_cnt_inc == WGT_FULL) begin
              w_state_nxt = ST_COMPUTE;
            end else begin
              w_state_nxt = ST_WAIT_W;
            end
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_short     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_W: begin
        w_overrun = in_valid;
        if (w_wgt_cnt_inc == WGT_FULL) begin
          w_state_nxt = ST_COMPUTE;
        end else begin
          w_state_nxt = ST_WAIT_W;
        end
      end
      ST_COMPUTE: begin
        w_overrun = in_valid;
        if (w_hs && w_win_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        w_overrun = in_valid;
        if (w_res_inc >= RES_FULL) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Rewind the window walk at frame start and after the last window
    w_ag_clr = w_frame_start || (w_hs && w_win_last);
  end

  // Counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifm_cnt     <= '0;
      r_wgt_cnt     <= '0;
      r_res_cnt     <= '0;
      r_ifm_wr_en   <= 1'b0;
      r_ifm_wr_addr <= '0;
      r_ifm_wr_data <= '0;
      r_wgt_wr_en   <= 1'b0;
      r_wgt_wr_addr <= '0;
      r_wgt_wr_data <= '0;
      r_win_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_ifm_wr_en <= w_ifm_acc;
      if (w_ifm_acc) begin
        r_ifm_wr_addr <= w_ifm_idx;
        r_ifm_wr_data <= In_IFM_1;
        if (w_ifm_idx == IFM_LAST) begin
          r_ifm_cnt <= '0;
        end else begin
          r_ifm_cnt <= w_ifm_idx + 6'd1;
        end
      end else if (w_short) begin
        r_ifm_cnt <= '0;
      end else begin
        r_ifm_cnt <= r_ifm_cnt;
      end

      r_wgt_wr_en <= w_wgt_acc;
      if (w_wgt_acc) begin
        r_wgt_wr_addr <= r_wgt_cnt;
        r_wgt_wr_data <= In_Weight_1;
      end else begin
        r_wgt_wr_addr <= r_wgt_wr_addr;
        r_wgt_wr_data <= r_wgt_wr_data;
      end
      if (w_short || w_done) begin
        r_wgt_cnt <= '0;
      end else begin
        r_wgt_cnt <= w_wgt_cnt_inc;
      end

      if (w_done) begin
        r_res_cnt <= '0;
      end else begin
        r_res_cnt <= w_res_inc;
      end

      r_win_valid   <= (w_state_nxt == ST_COMPUTE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_frame_done  <= w_done;
      r_err_short   <= w_short;
      r_err_overrun <= w_overrun;
    end
  end

  conv_win_addr_gen u_win_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_ag_clr),
    .i_en   (w_hs),
    .o_base (w_win_base),
    .o_last (w_win_last)
  );

  assign ifm_wr_en   = r_ifm_wr_en;
  assign ifm_wr_addr = r_ifm_wr_addr;
  assign ifm_wr_data = r_ifm_wr_data;
  assign wgt_wr_en   = r_wgt_wr_en;
  assign wgt_wr_addr = r_wgt_wr_addr;
  assign wgt_wr_data = r_wgt_wr_data;
  assign win_valid   = r_win_valid;
  assign win_base    = w_win_base;
  assign win_last    = w_win_last;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign err_short   = r_err_short;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Self-checking bench for conv_frame_scheduler: randomized frames checked
// against the expected raster of window origins and stream write indices.
module tb_conv_frame_scheduler;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] In_IFM_1 = '0;
  logic              weight_valid = 1'b0;
  logic [DATA_W-1:0] In_Weight_1 = '0;
  logic              win_ready = 1'b0;
  logic              mac_done = 1'b0;
  logic              ifm_wr_en, wgt_wr_en, win_valid, win_last;
  logic              busy, frame_done, err_short, err_overrun;
  logic [ADDR_W-1:0] ifm_wr_addr, win_base;
  logic [3:0]        wgt_wr_addr;
  logic [DATA_W-1:0] ifm_wr_data, wgt_wr_data;
  logic [55:0]       all_outs;

  always #5 clk = ~clk;

  conv_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .In_IFM_1(In_IFM_1),
    .weight_valid(weight_valid), .In_Weight_1(In_Weight_1),
    .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr), .ifm_wr_data(ifm_wr_data),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_base(win_base),
    .win_last(win_last), .mac_done(mac_done), .busy(busy),
    .frame_done(frame_done), .err_short(err_short), .err_overrun(err_overrun)
  );

  assign all_outs = {ifm_wr_en, ifm_wr_addr, ifm_wr_data, wgt_wr_en, wgt_wr_addr,
                     wgt_wr_data, win_valid, win_base, win_last, busy, frame_done,
                     err_short, err_overrun};

  int vectors = 0;
  int miscompares = 0;

  // Observations of the most recent run_frame call
  int                ifm_addr_q[$];
  logic [DATA_W-1:0] ifm_data_q[$];
  int                wgt_addr_q[$];
  logic [DATA_W-1:0] wgt_data_q[$];
  int                base_q[$];
  bit                last_q[$];
  int n_done, done_iter, last_mac_iter, n_short, short_iter, n_over;
  int stall_bad, early, first_valid_iter, wgt9_iter, timed_out, n_hs;
  logic [DATA_W-1:0] sent_ifm [0:N_IFM-1];
  logic [DATA_W-1:0] sent_wgt [0:15];

  // Reference: n-th window origin in raster order over the valid output grid
  function automatic int exp_base(input int n);
    return (n / OUT_DIM) * IFM_DIM + (n % OUT_DIM);
  endfunction

  // Drives one frame and records what the DUT produced. Iteration "it"
  // samples outputs #1 after an edge, then sets inputs for the next edge.
  task automatic run_frame(input int n_ifm, input int wdelay, input int n_wgt,
                           input int rdy_mode, input int over_at,
                           input int abort_hs, input int tail, input bit seq_data);
    int it, tail_cnt, prev_base;
    int due_q[$];
    bit prev_valid, prev_hs, hs;
    ifm_addr_q.delete(); ifm_data_q.delete(); wgt_addr_q.delete(); wgt_data_q.delete();
    base_q.delete(); last_q.delete();
    n_done = 0; done_iter = -1; last_mac_iter = -1; n_short = 0; short_iter = -1;
    n_over = 0; stall_bad = 0; early = 0; first_valid_iter = -1; wgt9_iter = -1; n_hs = 0;
    it = 0; tail_cnt = -1; prev_valid = 1'b0; prev_hs = 1'b0; prev_base = 0;
    while (it < 700) begin
      if (it > 0) begin
        if (ifm_wr_en) begin
          ifm_addr_q.push_back(int'(ifm_wr_addr)); ifm_data_q.push_back(ifm_wr_data);
        end
        if (wgt_wr_en) begin
          wgt_addr_q.push_back(int'(wgt_wr_addr)); wgt_data_q.push_back(wgt_wr_data);
          if (wgt_addr_q.size() == N_WGT) wgt9_iter = it;
        end
        if (win_valid && first_valid_iter < 0) first_valid_iter = it;
        if (win_valid && wgt_addr_q.size() < N_WGT) early++;
        if (prev_valid && !prev_hs && (!win_valid || int'(win_base) != prev_base)) stall_bad++;
        if (frame_done) begin n_done++; done_iter = it; if (tail_cnt < 0) tail_cnt = tail; end
        if (err_short) begin n_short++; short_iter = it; if (tail_cnt < 0) tail_cnt = tail; end
        if (err_overrun) n_over++;
      end
      if (abort_hs >= 0 && n_hs >= abort_hs) break;
      if (tail_cnt == 0) break;
      if (tail_cnt > 0) tail_cnt--;

      in_valid = (it < n_ifm) ||
                 (over_at >= 0 && first_valid_iter >= 0 && it == first_valid_iter + over_at);
      if (it < n_ifm) begin
        In_IFM_1 = seq_data ? DATA_W'(it + 1) : DATA_W'($urandom);
        sent_ifm[it] = In_IFM_1;
      end else begin
        In_IFM_1 = DATA_W'($urandom);
      end
      weight_valid = (it >= wdelay) && (it < wdelay + n_wgt);
      if (weight_valid) begin
        In_Weight_1 = seq_data ? DATA_W'(it - wdelay + 100) : DATA_W'($urandom);
        sent_wgt[it - wdelay] = In_Weight_1;
      end else begin
        In_Weight_1 = DATA_W'($urandom);
      end
      case (rdy_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ((it % 4) == 0) || ((it % 4) == 3);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      mac_done = 1'b0;
      if (due_q.size() > 0) begin
        if (due_q[0] == it) begin
          mac_done = 1'b1; void'(due_q.pop_front()); last_mac_iter = it;
        end
      end
      hs = win_valid && win_ready;
      if (hs) begin
        due_q.push_back(it + 2); n_hs++;
        base_q.push_back(int'(win_base)); last_q.push_back(win_last);
      end
      prev_valid = win_valid; prev_hs = hs; prev_base = int'(win_base);
      @(posedge clk); #1;
      it++;
    end
    timed_out = (it >= 700) ? 1 : 0;
    in_valid = 1'b0; weight_valid = 1'b0; win_ready = 1'b0; mac_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (all_outs !== 56'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_nominal;
    run_frame(N_IFM, int'($urandom_range(0, 10)), N_WGT, 0, -1, -1, 3, 1'b1);
    vectors++;
    if (timed_out != 0 || ifm_addr_q.size() != N_IFM || wgt_addr_q.size() != N_WGT) begin
      miscompares++;
      $display("FAIL nominal_counts: timeout %0d ifm %0d wgt %0d expected 0/49/9",
               timed_out, ifm_addr_q.size(), wgt_addr_q.size());
    end
    for (int i = 0; i < ifm_addr_q.size(); i++) begin
      vectors++;
      if (ifm_addr_q[i] != i || ifm_data_q[i] !== DATA_W'(i + 1)) begin
        miscompares++;
        $display("FAIL nominal_ifm[%0d]: got addr %0d data %0d expected %0d/%0d",
                 i, ifm_addr_q[i], ifm_data_q[i], i, i + 1);
      end
    end
    for (int i = 0; i < wgt_addr_q.size(); i++) begin
      vectors++;
      if (wgt_addr_q[i] != i || wgt_data_q[i] !== sent_wgt[i]) begin
        miscompares++;
        $display("FAIL nominal_wgt[%0d]: got addr %0d data %h expected %0d/%h",
                 i, wgt_addr_q[i], wgt_data_q[i], i, sent_wgt[i]);
      end
    end
    vectors++;
    if (base_q.size() != N_OUT) begin
      miscompares++; $display("FAIL nominal_windows: got %0d expected %0d", base_q.size(), N_OUT);
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i) || last_q[i] != (i == N_OUT - 1)) begin
        miscompares++;
        $display("FAIL nominal_win[%0d]: got base %0d last %0d expected %0d/%0d",
                 i, base_q[i], last_q[i], exp_base(i), (i == N_OUT - 1));
      end
    end
    vectors++;
    if (n_done != 1 || done_iter != last_mac_iter + 1) begin
      miscompares++;
      $display("FAIL nominal_done: got %0d pulses at %0d expected 1 at %0d",
               n_done, done_iter, last_mac_iter + 1);
    end
    vectors++;
    if (first_valid_iter != N_IFM || busy !== 1'b0 || n_over != 0 || n_short != 0) begin
      miscompares++;
      $display("FAIL nominal_misc: got first_valid %0d busy %b over %0d short %0d expected 49/0/0/0",
               first_valid_iter, busy, n_over, n_short);
    end
  endtask

  task automatic test_backpressure;
    run_frame(N_IFM, 0, N_WGT, 1, -1, -1, 3, 1'b0);
    vectors++;
    if (timed_out != 0 || base_q.size() != N_OUT || stall_bad != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL bp_summary: got timeout %0d hs %0d stall_bad %0d done %0d expected 0/25/0/1",
               timed_out, base_q.size(), stall_bad, n_done);
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i)) begin
        miscompares++;
        $display("FAIL bp_win[%0d]: got %0d expected %0d", i, base_q[i], exp_base(i));
      end
    end
  endtask

  task automatic test_late_weights;
    run_frame(N_IFM, N_IFM + 4, N_WGT, 0, -1, -1, 3, 1'b0);
    vectors++;
    if (early != 0 || first_valid_iter != wgt9_iter || wgt9_iter != N_IFM + 4 + N_WGT) begin
      miscompares++;
      $display("FAIL late_wgt_start: got early %0d first_valid %0d wgt9 %0d expected 0/%0d/%0d",
               early, first_valid_iter, wgt9_iter, N_IFM + 4 + N_WGT, N_IFM + 4 + N_WGT);
    end
    vectors++;
    if (timed_out != 0 || base_q.size() != N_OUT || n_done != 1) begin
      miscompares++;
      $display("FAIL late_wgt_frame: got timeout %0d windows %0d done %0d expected 0/25/1",
               timed_out, base_q.size(), n_done);
    end
    vectors++;
    if (base_q.size() == 0 || base_q[0] != 0) begin
      miscompares++;
      $display("FAIL late_wgt_first_base: got %0d windows, first %0d expected 0",
               base_q.size(), (base_q.size() > 0) ? base_q[0] : -1);
    end
  endtask

  task automatic test_short_burst;
    run_frame(20, 2, 3, 0, -1, -1, 3, 1'b0);
    vectors++;
    if (n_short != 1 || short_iter != 21 || busy !== 1'b0 || n_done != 0 || base_q.size() != 0) begin
      miscompares++;
      $display("FAIL short_err: got pulses %0d at %0d busy %b done %0d windows %0d expected 1/21/0/0/0",
               n_short, short_iter, busy, n_done, base_q.size());
    end
    vectors++;
    if (ifm_addr_q.size() != 20 || wgt_addr_q.size() != 3) begin
      miscompares++;
      $display("FAIL short_writes: got ifm %0d wgt %0d expected 20/3", ifm_addr_q.size(), wgt_addr_q.size());
    end
    run_frame(N_IFM, 5, N_WGT, 2, -1, -1, 3, 1'b0);
    vectors++;
    if (timed_out != 0 || ifm_addr_q.size() != N_IFM || wgt_addr_q.size() != N_WGT || n_done != 1) begin
      miscompares++;
      $display("FAIL short_recover: got timeout %0d ifm %0d wgt %0d done %0d expected 0/49/9/1",
               timed_out, ifm_addr_q.size(), wgt_addr_q.size(), n_done);
    end
    for (int i = 0; i < ifm_addr_q.size(); i++) begin
      vectors++;
      if (ifm_addr_q[i] != i || ifm_data_q[i] !== sent_ifm[i]) begin
        miscompares++;
        $display("FAIL short_recover_ifm[%0d]: got addr %0d expected %0d", i, ifm_addr_q[i], i);
      end
    end
    for (int i = 0; i < wgt_addr_q.size(); i++) begin
      vectors++;
      if (wgt_addr_q[i] != i) begin
        miscompares++;
        $display("FAIL short_recover_wgt[%0d]: got addr %0d expected %0d", i, wgt_addr_q[i], i);
      end
    end
  endtask

  task automatic test_overrun_extra_weights;
    run_frame(N_IFM, 0, 12, 0, 3, -1, 3, 1'b0);
    vectors++;
    if (n_over != 1 || ifm_addr_q.size() != N_IFM || wgt_addr_q.size() != N_WGT) begin
      miscompares++;
      $display("FAIL overrun: got over %0d ifm %0d wgt %0d expected 1/49/9",
               n_over, ifm_addr_q.size(), wgt_addr_q.size());
    end
    for (int i = 0; i < wgt_data_q.size(); i++) begin
      vectors++;
      if (wgt_data_q[i] !== sent_wgt[i] || wgt_addr_q[i] != i) begin
        miscompares++;
        $display("FAIL overrun_wgt[%0d]: got %h@%0d expected %h@%0d",
                 i, wgt_data_q[i], wgt_addr_q[i], sent_wgt[i], i);
      end
    end
    vectors++;
    if (timed_out != 0 || base_q.size() != N_OUT || n_done != 1) begin
      miscompares++;
      $display("FAIL overrun_frame: got timeout %0d windows %0d done %0d expected 0/25/1",
               timed_out, base_q.size(), n_done);
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i)) begin
        miscompares++;
        $display("FAIL overrun_win[%0d]: got %0d expected %0d", i, base_q[i], exp_base(i));
      end
    end
  endtask

  task automatic test_reset_mid_compute;
    run_frame(N_IFM, 0, N_WGT, 0, -1, 10, 0, 1'b0);
    vectors++;
    if (base_q.size() != 10 || n_done != 0) begin
      miscompares++;
      $display("FAIL midreset_pre: got windows %0d done %0d expected 10/0", base_q.size(), n_done);
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i)) begin
        miscompares++;
        $display("FAIL midreset_win[%0d]: got %0d expected %0d", i, base_q[i], exp_base(i));
      end
    end
    rst = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (all_outs !== 56'd0) begin
      miscompares++; $display("FAIL midreset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0; win_ready = 1'b0;
    run_frame(N_IFM, 1, N_WGT, 2, -1, -1, 3, 1'b0);
    vectors++;
    if (timed_out != 0 || base_q.size() != N_OUT || n_done != 1 || wgt_addr_q.size() != N_WGT) begin
      miscompares++;
      $display("FAIL midreset_after: got timeout %0d windows %0d done %0d wgt %0d expected 0/25/1/9",
               timed_out, base_q.size(), n_done, wgt_addr_q.size());
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i)) begin
        miscompares++;
        $display("FAIL midreset_after_win[%0d]: got %0d expected %0d", i, base_q[i], exp_base(i));
      end
    end
  endtask

  task automatic test_back_to_back;
    run_frame(N_IFM, 3, N_WGT, 2, -1, -1, 0, 1'b0);
    vectors++;
    if (timed_out != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL b2b_first: got timeout %0d done %0d expected 0/1", timed_out, n_done);
    end
    // Next frame starts in the frame_done cycle itself
    run_frame(N_IFM, 0, N_WGT, 2, -1, -1, 3, 1'b0);
    vectors++;
    if (timed_out != 0 || n_done != 1 || base_q.size() != N_OUT ||
        ifm_addr_q.size() != N_IFM || first_valid_iter != N_IFM) begin
      miscompares++;
      $display("FAIL b2b_second: got timeout %0d done %0d windows %0d ifm %0d first_valid %0d expected 0/1/25/49/49",
               timed_out, n_done, base_q.size(), ifm_addr_q.size(), first_valid_iter);
    end
    for (int i = 0; i < ifm_addr_q.size(); i++) begin
      vectors++;
      if (ifm_addr_q[i] != i || ifm_data_q[i] !== sent_ifm[i]) begin
        miscompares++;
        $display("FAIL b2b_ifm[%0d]: got %0d/%h expected %0d/%h",
                 i, ifm_addr_q[i], ifm_data_q[i], i, sent_ifm[i]);
      end
    end
    for (int i = 0; i < base_q.size(); i++) begin
      vectors++;
      if (base_q[i] != exp_base(i) || last_q[i] != (i == N_OUT - 1)) begin
        miscompares++;
        $display("FAIL b2b_win[%0d]: got %0d/%0d expected %0d/%0d",
                 i, base_q[i], last_q[i], exp_base(i), (i == N_OUT - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_late_weights();
    test_short_burst();
    test_overrun_extra_weights();
    test_reset_mid_compute();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
